// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and ALUControl encodings for the ALU arbiter
package alu_arb_pkg;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first valid index after ptr (wrapping)
module rr_picker import alu_arb_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   int j;

   // scan farthest-to-nearest so the nearest valid index after ptr wins
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = ID_W'(j);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one external ALU; optional rsp_zero via ALU_ARB_ZERO_FLAG_EN
module alu_arbiter import alu_arb_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*3-1:0]      req_op,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [2:0]                alu_ctrl,
   input  logic [DATA_W-1:0]         alu_result,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [ID_W-1:0]           rsp_id
`ifdef ALU_ARB_ZERO_FLAG_EN
   ,output logic                     rsp_zero
`endif
);

   state_t              state, state_nxt;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     win, rr_ptr;
   logic                any;

   rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win),
      .any   (any)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // next state: one grant, one execute cycle, then hold the response until taken
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = any ? EXEC : IDLE;
         EXEC:    state_nxt = RESP;
         default: state_nxt = rsp_ready ? IDLE : RESP;
      endcase
   end

   // outputs: accept pulse only while idle, response valid only in RESP
   always_comb begin
      req_ready = (state == IDLE) ? grant : '0;
      rsp_valid = (state == RESP);
   end

   // operand latch on grant, result capture in EXEC; everything else holds
   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_ctrl <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
         rr_ptr   <= ID_W'(NUM_REQ - 1);
`ifdef ALU_ARB_ZERO_FLAG_EN
         rsp_zero <= 1'b0;
`endif
      end else begin
         if (state == IDLE && any) begin
            alu_a    <= req_a[int'(win)*DATA_W +: DATA_W];
            alu_b    <= req_b[int'(win)*DATA_W +: DATA_W];
            alu_ctrl <= req_op[int'(win)*3 +: 3];
            rsp_id   <= win;
            rr_ptr   <= win;
         end
         if (state == EXEC) begin
            rsp_data <= alu_result;
`ifdef ALU_ARB_ZERO_FLAG_EN
            rsp_zero <= (alu_result == '0);
`endif
         end
      end
   end

endmodule
